// File: rtl/gfx_rom_responder.sv
// Toggle-handshake ROM responder: assembles 32-bit words from two 16-bit memory
// beats and answers repeats of the last fetched word from a one-entry cache.
module gfx_rom_responder #(
   parameter int unsigned ADDR_WIDTH = 21,
   parameter bit          HIT_EN     = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] rom_address,
   input  logic                  rom_req,
   output logic                  rom_ack,
   output logic [31:0]           rom_data,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [15:0]           mem_data,
   input  logic                  mem_ready,
   input  logic                  invalidate
);

   localparam int unsigned WORD_W = ADDR_WIDTH - 2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LO   = 2'd1,
      S_HI   = 2'd2,
      S_ACK  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [WORD_W-1:0]   req_word_q, req_word_d;
   logic [WORD_W-1:0]   tag_q, tag_d;
   logic                valid_q, valid_d;
   logic                rom_ack_q, rom_ack_d;
   logic [31:0]         rom_data_q, rom_data_d;
   logic                mem_req_q, mem_req_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;

   logic [WORD_W-1:0]   addr_word_c;
   logic                pending_c;
   logic                hit_c;
   logic                unused_addr_lsbs;

   assign addr_word_c      = rom_address[ADDR_WIDTH-1:2];
   assign unused_addr_lsbs = ^rom_address[1:0];
   assign pending_c        = (rom_req != rom_ack_q);
   // The cached word is the last word returned, which rom_data still holds.
   assign hit_c            = HIT_EN && valid_q && (tag_q == addr_word_c) && !invalidate;

   always_comb begin
      state_d    = state_q;
      req_word_d = req_word_q;
      tag_d      = tag_q;
      valid_d    = valid_q;
      rom_ack_d  = rom_ack_q;
      rom_data_d = rom_data_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;

      case (state_q)
         S_IDLE: begin
            if (pending_c) begin
               req_word_d = addr_word_c;
               if (hit_c) begin
                  rom_ack_d = ~rom_ack_q;
               end else begin
                  state_d    = S_LO;
                  mem_req_d  = 1'b1;
                  mem_addr_d = {addr_word_c, 2'b00};
               end
            end
         end
         S_LO: begin
            if (mem_ready) begin
               rom_data_d[15:0] = mem_data;
               mem_addr_d       = {req_word_q, 2'b10};
               state_d          = S_HI;
            end
         end
         S_HI: begin
            if (mem_ready) begin
               rom_data_d[31:16] = mem_data;
               mem_req_d         = 1'b0;
               state_d           = S_ACK;
            end
         end
         S_ACK: begin
            rom_ack_d = ~rom_ack_q;
            tag_d     = req_word_q;
            valid_d   = 1'b1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Invalidate wins over a same-cycle refill; earlier pulses leave the refill intact.
      if (invalidate) valid_d = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         req_word_q <= '0;
         tag_q      <= '0;
         valid_q    <= 1'b0;
         rom_ack_q  <= 1'b0;
         rom_data_q <= '0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         req_word_q <= req_word_d;
         tag_q      <= tag_d;
         valid_q    <= valid_d;
         rom_ack_q  <= rom_ack_d;
         rom_data_q <= rom_data_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
      end
   end

   assign rom_ack  = rom_ack_q;
   assign rom_data = rom_data_q;
   assign mem_req  = mem_req_q;
   assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_gfx_rom_responder.sv
// Directed bench for gfx_rom_responder: cached DUT plus a HIT_EN=0 instance.
module tb_gfx_rom_responder;

   localparam int unsigned AW = 21;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] rom_address;
   logic          rom_req;
   logic          rom_ack;
   logic [31:0]   rom_data;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic [15:0]   mem_data;
   logic          mem_ready;
   logic          invalidate;

   logic          nc_rom_req;
   logic          nc_rom_ack;
   logic [31:0]   nc_rom_data;
   logic          nc_mem_req;
   logic [AW-1:0] nc_mem_addr;
   logic [15:0]   nc_mem_data;
   logic          nc_mem_ready;

   int checks = 0;
   int errors = 0;

   gfx_rom_responder #(.ADDR_WIDTH(AW), .HIT_EN(1'b1)) u_dut (
      .clk(clk), .reset(reset), .rom_address(rom_address), .rom_req(rom_req),
      .rom_ack(rom_ack), .rom_data(rom_data), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_data(mem_data), .mem_ready(mem_ready), .invalidate(invalidate)
   );

   gfx_rom_responder #(.ADDR_WIDTH(AW), .HIT_EN(1'b0)) u_dut_nc (
      .clk(clk), .reset(reset), .rom_address(rom_address), .rom_req(nc_rom_req),
      .rom_ack(nc_rom_ack), .rom_data(nc_rom_data), .mem_req(nc_mem_req), .mem_addr(nc_mem_addr),
      .mem_data(nc_mem_data), .mem_ready(nc_mem_ready), .invalidate(invalidate)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for mem_req, checks the beat address stays put, then returns one beat.
   task automatic do_beat(input logic [AW-1:0] exp_addr, input logic [15:0] d, input int waits, input string nm);
      int n;
      n = 0;
      while (mem_req !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== exp_addr) begin
         errors++;
         $display("FAIL %s_addr: mem_req=%b mem_addr=%h, expected mem_req=1 mem_addr=%h", nm, mem_req, mem_addr, exp_addr);
      end
      for (int i = 0; i < waits; i++) begin
         tick();
         checks++;
         if (mem_req !== 1'b1 || mem_addr !== exp_addr) begin
            errors++;
            $display("FAIL %s_hold: mem_req=%b mem_addr=%h, expected mem_req=1 mem_addr=%h", nm, mem_req, mem_addr, exp_addr);
         end
      end
      mem_ready = 1'b1;
      mem_data  = d;
      tick();
      mem_ready = 1'b0;
      mem_data  = 16'h0000;
   endtask

   task automatic wait_ack(input logic [31:0] exp_data, input string nm);
      int n;
      n = 0;
      while (rom_ack !== rom_req && n < 30) begin
         tick();
         n++;
      end
      checks++;
      if (rom_ack !== rom_req || rom_data !== exp_data) begin
         errors++;
         $display("FAIL %s_ack: rom_ack=%b rom_data=%h, expected rom_ack=%b rom_data=%h", nm, rom_ack, rom_data, rom_req, exp_data);
      end
   endtask

   task automatic expect_hit(input logic [AW-1:0] addr, input logic [31:0] exp_data, input string nm);
      rom_address = addr;
      rom_req     = ~rom_req;
      tick();
      checks++;
      if (rom_ack !== rom_req || mem_req !== 1'b0 || rom_data !== exp_data) begin
         errors++;
         $display("FAIL %s: rom_ack=%b mem_req=%b rom_data=%h, expected rom_ack=%b mem_req=0 rom_data=%h",
                  nm, rom_ack, mem_req, rom_data, rom_req, exp_data);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; rom_address = '0; rom_req = 1'b0; mem_data = '0; mem_ready = 1'b0; invalidate = 1'b0;
      nc_rom_req = 1'b0; nc_mem_data = '0; nc_mem_ready = 1'b0;
      tick();
      tick();
      checks++;
      if (rom_ack !== 1'b0 || rom_data !== 32'h0 || mem_req !== 1'b0 || mem_addr !== 21'h0) begin
         errors++;
         $display("FAIL reset_values: rom_ack=%b rom_data=%h mem_req=%b mem_addr=%h, expected all zero", rom_ack, rom_data, mem_req, mem_addr);
      end
      reset = 1'b0;
      tick();
      tick();
      checks++;
      if (mem_req !== 1'b0 || rom_ack !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: mem_req=%b rom_ack=%b, expected 0 0", mem_req, rom_ack);
      end
   endtask

   task automatic test_miss();
      logic old_ack;
      old_ack     = rom_ack;
      rom_address = 21'h000104;
      rom_req     = ~rom_req;
      tick();
      do_beat(21'h000104, 16'hBEEF, 2, "miss_lo");
      do_beat(21'h000106, 16'h1234, 2, "miss_hi");
      checks++;
      if (mem_req !== 1'b0 || rom_ack !== old_ack) begin
         errors++;
         $display("FAIL miss_ack_cycle: mem_req=%b rom_ack=%b, expected mem_req=0 rom_ack=%b", mem_req, rom_ack, old_ack);
      end
      tick();
      checks++;
      if (rom_ack !== ~old_ack || rom_data !== 32'h1234BEEF) begin
         errors++;
         $display("FAIL miss_data: rom_ack=%b rom_data=%h, expected rom_ack=%b rom_data=1234beef", rom_ack, rom_data, ~old_ack);
      end
      repeat (3) tick();
      checks++;
      if (rom_ack !== ~old_ack || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL miss_single_ack: rom_ack=%b mem_req=%b, expected rom_ack=%b mem_req=0", rom_ack, mem_req, ~old_ack);
      end
   endtask

   task automatic test_hit();
      expect_hit(21'h000107, 32'h1234BEEF, "hit_107");
      expect_hit(21'h000104, 32'h1234BEEF, "hit_104");
   endtask

   task automatic test_invalidate();
      invalidate = 1'b1;
      tick();
      invalidate = 1'b0;
      rom_address = 21'h000104;
      rom_req     = ~rom_req;
      tick();
      do_beat(21'h000104, 16'h5555, 1, "inval_lo");
      do_beat(21'h000106, 16'hAAAA, 1, "inval_hi");
      wait_ack(32'hAAAA5555, "inval");
      // Invalidate in the same cycle as a would-be hit turns it into a miss.
      rom_req    = ~rom_req;
      invalidate = 1'b1;
      tick();
      invalidate = 1'b0;
      checks++;
      if (mem_req !== 1'b1 || rom_ack === rom_req) begin
         errors++;
         $display("FAIL inval_same_cycle: mem_req=%b rom_ack=%b, expected mem_req=1 rom_ack=%b", mem_req, rom_ack, ~rom_req);
      end
      do_beat(21'h000104, 16'h1357, 1, "inval2_lo");
      do_beat(21'h000106, 16'h2468, 1, "inval2_hi");
      wait_ack(32'h24681357, "inval2");
   endtask

   task automatic test_inval_in_flight();
      rom_address = 21'h000300;
      rom_req     = ~rom_req;
      tick();
      invalidate = 1'b1;
      tick();
      invalidate = 1'b0;
      do_beat(21'h000300, 16'h0A0A, 1, "flight_lo");
      do_beat(21'h000302, 16'h0B0B, 1, "flight_hi");
      wait_ack(32'h0B0B0A0A, "flight");
      expect_hit(21'h000300, 32'h0B0B0A0A, "flight_refill_hit");
      expect_hit(21'h000302, 32'h0B0B0A0A, "flight_lsb_hit");
   endtask

   task automatic test_reset_mid_hi();
      rom_address = 21'h000500;
      rom_req     = 1'b1;
      tick();
      do_beat(21'h000500, 16'h1111, 1, "rst_lo");
      tick();
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 21'h000502) begin
         errors++;
         $display("FAIL rst_in_hi: mem_req=%b mem_addr=%h, expected 1 000502", mem_req, mem_addr);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (mem_req !== 1'b0 || rom_ack !== 1'b0 || rom_data !== 32'h0) begin
         errors++;
         $display("FAIL rst_async: mem_req=%b rom_ack=%b rom_data=%h, expected 0 0 00000000", mem_req, rom_ack, rom_data);
      end
      tick();
      reset = 1'b0;
      tick();
      do_beat(21'h000500, 16'h2222, 1, "rst_re_lo");
      do_beat(21'h000502, 16'h3333, 1, "rst_re_hi");
      wait_ack(32'h33332222, "rst_refetch");
   endtask

   task automatic test_double_toggle();
      rom_address = 21'h000400;
      rom_req     = ~rom_req;
      tick();
      rom_req     = ~rom_req;
      rom_address = 21'h000700;
      tick();
      rom_req = ~rom_req;
      do_beat(21'h000400, 16'h4444, 1, "dbl_lo");
      do_beat(21'h000402, 16'h4545, 1, "dbl_hi");
      wait_ack(32'h45454444, "dbl");
      repeat (4) tick();
      checks++;
      if (mem_req !== 1'b0 || rom_ack !== rom_req) begin
         errors++;
         $display("FAIL dbl_quiet: mem_req=%b rom_ack=%b, expected mem_req=0 rom_ack=%b", mem_req, rom_ack, rom_req);
      end
   endtask

   task automatic test_back_to_back();
      logic old_ack;
      old_ack     = rom_ack;
      rom_address = 21'h000104;
      rom_req     = ~rom_req;
      tick();
      do_beat(21'h000104, 16'hBEEF, 1, "b2b1_lo");
      do_beat(21'h000106, 16'h1234, 1, "b2b1_hi");
      rom_address = 21'h000200;
      rom_req     = ~rom_req;
      tick();
      checks++;
      if (rom_ack !== ~old_ack || rom_data !== 32'h1234BEEF || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL b2b_first_ack: rom_ack=%b rom_data=%h mem_req=%b, expected %b 1234beef 0", rom_ack, rom_data, mem_req, ~old_ack);
      end
      mem_ready = 1'b1;
      mem_data  = 16'hDEAD;
      tick();
      mem_ready = 1'b0;
      mem_data  = 16'h0000;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 21'h000200 || rom_data !== 32'h1234BEEF) begin
         errors++;
         $display("FAIL b2b_second_start: mem_req=%b mem_addr=%h rom_data=%h, expected 1 000200 1234beef", mem_req, mem_addr, rom_data);
      end
      do_beat(21'h000200, 16'h7777, 1, "b2b2_lo");
      do_beat(21'h000202, 16'h8888, 1, "b2b2_hi");
      wait_ack(32'h88887777, "b2b2");
   endtask

   task automatic test_hit_en0();
      logic [15:0] lo;
      logic [15:0] hi;
      rom_address = 21'h000104;
      for (int i = 0; i < 2; i++) begin
         lo = 16'h1000 + 16'(i);
         hi = 16'h2000 + 16'(i);
         nc_rom_req = ~nc_rom_req;
         tick();
         checks++;
         if (nc_mem_req !== 1'b1 || nc_mem_addr !== 21'h000104 || nc_rom_ack === nc_rom_req) begin
            errors++;
            $display("FAIL nocache_fetch%0d: mem_req=%b mem_addr=%h rom_ack=%b, expected 1 000104 %b", i, nc_mem_req, nc_mem_addr, nc_rom_ack, ~nc_rom_req);
         end
         nc_mem_ready = 1'b1;
         nc_mem_data  = lo;
         tick();
         checks++;
         if (nc_mem_addr !== 21'h000106) begin
            errors++;
            $display("FAIL nocache_hi_addr%0d: mem_addr=%h, expected 000106", i, nc_mem_addr);
         end
         nc_mem_data = hi;
         tick();
         nc_mem_ready = 1'b0;
         tick();
         checks++;
         if (nc_rom_ack !== nc_rom_req || nc_rom_data !== {hi, lo}) begin
            errors++;
            $display("FAIL nocache_ack%0d: rom_ack=%b rom_data=%h, expected %b %h", i, nc_rom_ack, nc_rom_data, nc_rom_req, {hi, lo});
         end
      end
   endtask

   initial begin
      test_reset();
      test_miss();
      test_hit();
      test_invalidate();
      test_inval_in_flight();
      test_reset_mid_hi();
      test_double_toggle();
      test_back_to_back();
      test_hit_en0();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1);
   end

endmodule

// File: doc/gfx_rom_responder.md
GFX_ROM_RESPONDER -- requirements
Module: gfx_rom_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 21: byte-address width of rom_address and mem_addr.
REQ-002 SHALL have parameter HIT_EN, default 1: 1 enables the single-entry last-fetch cache; 0 forces every request to fetch.
REQ-003 SHALL have port clk, input, 1: single clock; all logic rising-edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port rom_address, input, ADDR_WIDTH: byte address of the 32-bit word requested; bits [1:0] ignored.
REQ-006 SHALL have port rom_req, input, 1: toggle request; a new request is pending whenever rom_req != rom_ack.
REQ-007 SHALL have port rom_ack, output, 1: toggle acknowledge; set equal to rom_req when rom_data is valid.
REQ-008 SHALL have port rom_data, output, 32: fetched word; held stable until the next acknowledge.
REQ-009 SHALL have port mem_req, output, 1: level request to the 16-bit memory; held until mem_ready.
REQ-010 SHALL have port mem_addr, output, ADDR_WIDTH: byte address of the current 16-bit beat; bit 0 always 0.
REQ-011 SHALL have port mem_data, input, 16: beat data; valid in the cycle mem_ready=1.
REQ-012 SHALL have port mem_ready, input, 1: one-cycle beat completion strobe; ignored when mem_req=0.
REQ-013 SHALL have port invalidate, input, 1: single-cycle pulse that clears the cache entry.

Function
REQ-014 SHALL implement states IDLE, LO, HI and ACK; encoding is free.
REQ-015 In IDLE, with rom_req != rom_ack, SHALL capture rom_address[ADDR_WIDTH-1:2] into req_word.
REQ-016 In that same IDLE cycle, on a cache hit, SHALL drive rom_data from the cache and toggle rom_ack at the next edge; state remains IDLE.
REQ-017 A cache hit SHALL mean HIT_EN=1, cache valid, tag equal to rom_address[ADDR_WIDTH-1:2], and invalidate low that cycle.
REQ-018 In IDLE, on a cache miss, SHALL go to LO and assert mem_req with mem_addr={req_word,2'b00} at the next edge.
REQ-019 In LO, when mem_ready=1, SHALL store mem_data into rom_data[15:0], set mem_addr={req_word,2'b10} and go to HI; mem_req stays 1.
REQ-020 In HI, when mem_ready=1, SHALL store mem_data into rom_data[31:16], drop mem_req and go to ACK.
REQ-021 In ACK, SHALL set rom_ack=~rom_ack, load the tag with req_word, set cache valid, and return to IDLE; miss latency is 2 cycles plus both memory waits.
REQ-022 mem_req SHALL never drop before mem_ready in LO or HI; mem_addr SHALL be stable while mem_req=1.
REQ-023 rom_address and rom_req changes during LO, HI or ACK SHALL be ignored; the in-flight request completes with its captured address.
REQ-024 If rom_req toggles twice during one fetch, SHALL ack only the captured request; rom_ack then equals rom_req and no further fetch starts.
REQ-025 If rom_req toggles in the same cycle rom_ack toggles, SHALL detect the new request in IDLE on the following cycle.
REQ-026 invalidate in any state SHALL clear cache valid at the next edge; it SHALL NOT abort an in-flight fetch.
REQ-027 A fetch in flight when invalidate occurs SHALL still refill the cache at ACK.
REQ-028 mem_ready while mem_req=0 SHALL have no effect.
REQ-029 Address arithmetic SHALL be ADDR_WIDTH bits with no carry into the word index; the HI beat only sets bit 1.

Reset
REQ-030 While reset=1, SHALL force: state IDLE, rom_ack=0, rom_data=0, mem_req=0, mem_addr=0, cache valid=0, tag=0.
REQ-031 If reset asserts mid-fetch, SHALL drop mem_req immediately and discard the fetch; after release, a pending rom_req=1 SHALL start a fresh fetch.

Verification
REQ-032 Miss: rom_address=0x000104, toggle rom_req, memory returns 0xBEEF then 0x1234 with ready after 3 cycles each -> mem_addr 0x000104 then 0x000106; rom_data=0x1234BEEF; rom_ack toggles once.
REQ-033 Hit: repeat 0x000104 (also 0x000107) -> no mem_req, rom_ack toggles 1 cycle after detection, rom_data=0x1234BEEF.
REQ-034 Invalidate: pulse invalidate, request 0x000104 -> full two-beat fetch occurs; with HIT_EN=0, every request fetches.
REQ-035 Double toggle: toggle rom_req twice during the LO wait -> exactly one fetch and one ack; rom_ack==rom_req afterwards; mem_req stays 0.
REQ-036 Reset mid-HI: assert reset while mem_req=1 in HI -> mem_req=0 and rom_ack=0 immediately; after release with rom_req=1, a new fetch starts at the captured address.
REQ-037 Back-to-back: toggle rom_req for 0x000200 in the ack cycle of 0x000104 -> second fetch begins in IDLE 1 cycle later; stray mem_ready while idle is ignored.
